fadd_arbiter: RTL and testbench
===============================

FADD_ARBITER -- requirements
Module: fadd_arbiter

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning fixed cycles from fa_a/fa_b/fa_op change to the matching fa_result.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the grant counters.
REQ-003 clk  in  1  sole clock, all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous assertion, active-low.
REQ-005 reqN_valid  in  1  (N=0,1) requester N has an operation pending.
REQ-006 reqN_ready  out  1  (N=0,1) requester N is granted this cycle.
REQ-007 reqN_a, reqN_b  in  32  (N=0,1) IEEE-754 single-precision operands.
REQ-008 reqN_op  in  1  (N=0,1) operation select: 0 = add, 1 = subtract.
REQ-009 fa_a, fa_b  out  32  registered operands to the pipelined adder.
REQ-010 fa_op  out  1  registered operation to the adder.
REQ-011 fa_result  in  32  adder output.
REQ-012 rsp_data  out  32  result data, equal to fa_result.
REQ-013 rspN_valid  out  1  (N=0,1) rsp_data belongs to requester N; no backpressure.
REQ-014 idle  out  1  high when no operation is in flight.
REQ-015 cntN  out  CNT_W  (N=0,1) number of grants to requester N.

Function
REQ-016 reqN_ready SHALL be combinational; at most one is high per cycle.
REQ-017 Exactly one valid requester SHALL be granted.
REQ-018 With both valid, the requester not granted most recently SHALL win (round-robin); the last-grant pointer SHALL update only on a grant.
REQ-019 On a grant at edge k, fa_a/fa_b/fa_op SHALL load the winner's operands at edge k; with no grant they SHALL hold their values.
REQ-020 A tag {valid, id} SHALL shift through a LATENCY-entry register every cycle; a grant SHALL insert {1, winner}; no grant SHALL insert {0, x}.
REQ-021 In the cycle after edge k+LATENCY, rspN_valid SHALL be high for the granted id and rsp_data SHALL equal fa_result.
REQ-022 Throughput SHALL be one operation per cycle; back-to-back grants SHALL produce back-to-back responses in grant order.
REQ-023 idle SHALL be high if and only if no tag entry is valid; a grant in the current cycle does not clear idle until the next edge.
REQ-024 A requester SHALL hold valid and operands stable until ready; dropping valid without ready SHALL cancel the request with no side effects.

Reset
REQ-025 Reset SHALL clear all tag entries and set fa_a=0, fa_b=0, fa_op=0, rsp0_valid=rsp1_valid=0, idle=1, cnt0=cnt1=0, and the last-grant pointer to 1 (so port 0 wins the first contention).
REQ-026 Reset asserted mid-operation SHALL discard in-flight tags; no response for them SHALL appear after release.
REQ-027 reqN_ready SHALL be 0 while reset is asserted.

Configuration
REQ-028 With FADD_ARB_STATS_EN defined, cntN SHALL increment on each grant to N and saturate at all-ones.
REQ-029 Without FADD_ARB_STATS_EN, cntN SHALL be constant 0, with no counter registers.

Verification
REQ-030 Single request: req0 issues A=0x415a6666, B=0x41241687, op=0 at edge k -> fa_a/fa_b/fa_op updated at edge k; rsp0_valid one cycle after edge k+4 with rsp_data=fa_result; rsp1_valid stays 0.
REQ-031 Contention: both valid for 4 cycles after reset -> grants are 0,1,0,1; responses arrive on rsp0,rsp1,rsp0,rsp1 in consecutive cycles starting 5 cycles after the first grant.
REQ-032 Stream: req1 only, valid for 8 cycles with distinct operands -> 8 grants, 8 consecutive rsp1_valid cycles, data in order; idle returns high 5 cycles after the last grant.
REQ-033 Reset mid-flight: 3 grants, then rst low at edge k+2 for 1 cycle -> no rspN_valid afterwards, idle=1, cnt0=cnt1=0.
REQ-034 Stats (FADD_ARB_STATS_EN): 5 grants to 0 and 3 to 1 -> cnt0=5, cnt1=3; without the macro both counters read 0.

Source files
------------

// File: rtl/fadd_arbiter_if.sv
// Requester, pipelined-adder and response signals of fadd_arbiter.
// master = requesters plus adder model side, slave = the arbiter itself.
interface fadd_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic             req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic             req1_op;
  logic [31:0]      fa_a;
  logic [31:0]      fa_b;
  logic             fa_op;
  logic [31:0]      fa_result;
  logic [31:0]      rsp_data;
  logic             rsp0_valid;
  logic             rsp1_valid;
  logic             idle;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output fa_result,
    input  req0_ready, req1_ready, fa_a, fa_b, fa_op,
    input  rsp_data, rsp0_valid, rsp1_valid, idle, cnt0, cnt1
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  fa_result,
    output req0_ready, req1_ready, fa_a, fa_b, fa_op,
    output rsp_data, rsp0_valid, rsp1_valid, idle, cnt0, cnt1
  );
endinterface

// File: rtl/fadd_arbiter.sv
// Two-port round-robin arbiter in front of a fixed-latency FP adder, with id tag pipeline.
// Optional grant counters are enabled by defining FADD_ARB_STATS_EN.
module fadd_arbiter #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input logic           clk,
  input logic           rst,
  fadd_arbiter_if.slave bus
);

  logic               last_q;  // 1: port 1 was granted most recently
  logic               gnt0;
  logic               gnt1;
  logic               gnt;
  logic [31:0]        fa_a_q;
  logic [31:0]        fa_b_q;
  logic               fa_op_q;
  logic [LATENCY-1:0] tag_v;
  logic [LATENCY-1:0] tag_id;
  logic               rsp0_q;
  logic               rsp1_q;

  always_comb begin
    gnt0 = rst & bus.req0_valid & (~bus.req1_valid | last_q);
    gnt1 = rst & bus.req1_valid & (~bus.req0_valid | ~last_q);
    gnt  = gnt0 | gnt1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q  <= 1'b1;
      fa_a_q  <= '0;
      fa_b_q  <= '0;
      fa_op_q <= 1'b0;
      tag_v   <= '0;
      tag_id  <= '0;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
    end else begin
      if (gnt) begin
        last_q  <= gnt1;
        fa_a_q  <= gnt1 ? bus.req1_a  : bus.req0_a;
        fa_b_q  <= gnt1 ? bus.req1_b  : bus.req0_b;
        fa_op_q <= gnt1 ? bus.req1_op : bus.req0_op;
      end
      // Tag leaves the last stage on the same edge the adder result becomes visible.
      tag_v[0]  <= gnt;
      tag_id[0] <= gnt1;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      rsp0_q <= tag_v[LATENCY-1] & ~tag_id[LATENCY-1];
      rsp1_q <= tag_v[LATENCY-1] &  tag_id[LATENCY-1];
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.fa_a       = fa_a_q;
  assign bus.fa_b       = fa_b_q;
  assign bus.fa_op      = fa_op_q;
  assign bus.rsp_data   = bus.fa_result;
  assign bus.rsp0_valid = rsp0_q;
  assign bus.rsp1_valid = rsp1_q;
  assign bus.idle       = ~|tag_v;

`ifdef FADD_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt0 && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_W'(1);
      if (gnt1 && (cnt1_q != '1)) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;
`else
  assign bus.cnt0 = '0;
  assign bus.cnt1 = '0;
`endif

endmodule

// File: tb/tb_fadd_arbiter.sv
// Self-checking bench for fadd_arbiter: directed scenarios plus randomized traffic
// against a cycle-indexed scoreboard of expected grants and responses.
module tb_fadd_arbiter;
  localparam int L  = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fadd_arbiter_if #(.CNT_W(CW)) bus ();
  fadd_arbiter #(.LATENCY(L), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Stand-in adder: any operand-dependent function with exactly L cycles of latency.
  function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b, input logic op);
    return op ? (a - b) : (a + b);
  endfunction

  logic [31:0] apipe [L];
  always @(posedge clk) begin
    apipe[0] <= fmodel(bus.fa_a, bus.fa_b, bus.fa_op);
    for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
  end
  assign bus.fa_result = apipe[L-1];

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  logic        m_last;
  logic [31:0] m_fa_a, m_fa_b;
  logic        m_fa_op;
  int          m_lastg;
  int          m_cnt0, m_cnt1;
  int          exp_id  [int];
  logic [31:0] exp_dat [int];

  // Expectations for the current observation point
  logic            e_rdy0, e_rdy1, e_rsp0, e_rsp1, e_idle;
  logic [31:0]     e_data;
  logic [64:0]     e_fa;
  logic [2*CW-1:0] e_cnt;

  task automatic model_reset();
    m_last  = 1'b1;
    m_fa_a  = '0;
    m_fa_b  = '0;
    m_fa_op = 1'b0;
    m_lastg = -100;
    m_cnt0  = 0;
    m_cnt1  = 0;
    exp_id.delete();
    exp_dat.delete();
  endtask

  // Drives one cycle of requests, then computes what the DUT must show at the negedge.
  task automatic advance(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic op0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic op1);
    int w;
    @(posedge clk);
    #1;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
    @(negedge clk);
    e_rsp0 = exp_id.exists(cyc) ? (exp_id[cyc] == 0) : 1'b0;
    e_rsp1 = exp_id.exists(cyc) ? (exp_id[cyc] == 1) : 1'b0;
    e_data = exp_dat.exists(cyc) ? exp_dat[cyc] : '0;
    e_idle = !((cyc > m_lastg) && (cyc <= m_lastg + L));
    e_fa   = {m_fa_a, m_fa_b, m_fa_op};
    e_cnt  = {CW'(m_cnt0), CW'(m_cnt1)};
    w = -1;
    if (v0 && v1) w = m_last ? 0 : 1;
    else if (v0)  w = 0;
    else if (v1)  w = 1;
    e_rdy0 = (w == 0);
    e_rdy1 = (w == 1);
    if (w >= 0) begin
      exp_id[cyc+1+L]  = w;
      exp_dat[cyc+1+L] = (w == 0) ? fmodel(a0, b0, op0) : fmodel(a1, b1, op1);
      m_fa_a  = (w == 0) ? a0 : a1;
      m_fa_b  = (w == 0) ? b0 : b1;
      m_fa_op = (w == 0) ? op0 : op1;
      m_last  = (w == 1);
      m_lastg = cyc;
`ifdef FADD_ARB_STATS_EN
      if (w == 0 && m_cnt0 < (1 << CW) - 1) m_cnt0++;
      if (w == 1 && m_cnt1 < (1 << CW) - 1) m_cnt1++;
`endif
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'h1; bus.req0_b = 32'h2; bus.req0_op = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h3; bus.req1_b = 32'h4; bus.req1_op = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.idle} !== 5'b00001) begin
      fails++;
      $display("FAIL reset ctrl: got %b exp 00001", {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.idle});
    end
    checks++;
    if ({bus.fa_a, bus.fa_b, bus.fa_op, bus.cnt0, bus.cnt1} !== '0) begin
      fails++;
      $display("FAIL reset regs: got fa_a=%h fa_b=%h fa_op=%b cnt0=%0d cnt1=%0d exp all 0",
               bus.fa_a, bus.fa_b, bus.fa_op, bus.cnt0, bus.cnt1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_contention();
    logic [31:0] a0, b0, a1, b1;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    for (int i = 0; i < 4 + L + 3; i++) begin
      advance(i < 4, a0, b0, 1'b0, i < 4, a1, b1, 1'b1);
      checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.idle, bus.fa_a, bus.fa_b, bus.fa_op, bus.cnt0, bus.cnt1}
          !== {e_rdy0, e_rdy1, e_rsp0, e_rsp1, e_idle, e_fa, e_cnt}) begin
        fails++;
        $display("FAIL contention state cyc %0d: got %b_%h_%h exp %b_%h_%h", cyc,
                 {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.idle},
                 {bus.fa_a, bus.fa_b, bus.fa_op}, {bus.cnt0, bus.cnt1},
                 {e_rdy0, e_rdy1, e_rsp0, e_rsp1, e_idle}, e_fa, e_cnt);
      end
      if (e_rsp0 || e_rsp1) begin
        checks++;
        if (bus.rsp_data !== e_data) begin
          fails++;
          $display("FAIL contention data cyc %0d: got %h exp %h", cyc, bus.rsp_data, e_data);
        end
      end
      if (i < 4) begin
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          fails++;
          $display("FAIL contention order grant %0d: got %b exp %b", i, {bus.req0_ready, bus.req1_ready},
                   (i % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      if (e_rdy0) begin a0 = $urandom; b0 = $urandom; end
      if (e_rdy1) begin a1 = $urandom; b1 = $urandom; end
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < L + 3; i++) begin
      if (i == 0) advance(1'b1, 32'h415a6666, 32'h41241687, 1'b0, 1'b0, '0, '0, 1'b0);
      else        advance(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.idle, bus.fa_a, bus.fa_b, bus.fa_op, bus.cnt0, bus.cnt1}
          !== {e_rdy0, e_rdy1, e_rsp0, e_rsp1, e_idle, e_fa, e_cnt}) begin
        fails++;
        $display("FAIL single state cyc %0d: got %b_%h_%h exp %b_%h_%h", cyc,
                 {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.idle},
                 {bus.fa_a, bus.fa_b, bus.fa_op}, {bus.cnt0, bus.cnt1},
                 {e_rdy0, e_rdy1, e_rsp0, e_rsp1, e_idle}, e_fa, e_cnt);
      end
      if (e_rsp0 || e_rsp1) begin
        checks++;
        if (bus.rsp_data !== e_data) begin
          fails++;
          $display("FAIL single data cyc %0d: got %h exp %h", cyc, bus.rsp_data, e_data);
        end
      end
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8 + L + 3; i++) begin
      if (i < 8) advance(1'b0, '0, '0, 1'b0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
      else       advance(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.idle, bus.fa_a, bus.fa_b, bus.fa_op, bus.cnt0, bus.cnt1}
          !== {e_rdy0, e_rdy1, e_rsp0, e_rsp1, e_idle, e_fa, e_cnt}) begin
        fails++;
        $display("FAIL stream state cyc %0d: got %b_%h_%h exp %b_%h_%h", cyc,
                 {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.idle},
                 {bus.fa_a, bus.fa_b, bus.fa_op}, {bus.cnt0, bus.cnt1},
                 {e_rdy0, e_rdy1, e_rsp0, e_rsp1, e_idle}, e_fa, e_cnt);
      end
      if (e_rsp0 || e_rsp1) begin
        checks++;
        if (bus.rsp_data !== e_data) begin
          fails++;
          $display("FAIL stream data cyc %0d: got %h exp %h", cyc, bus.rsp_data, e_data);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) advance(1'b1, $urandom, $urandom, 1'b0, 1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.idle, bus.cnt0, bus.cnt1} !== {5'b00001, {2*CW{1'b0}}}) begin
      fails++;
      $display("FAIL midflight in-reset: got %b exp %b",
               {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.idle, bus.cnt0, bus.cnt1},
               {5'b00001, {2*CW{1'b0}}});
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req0_valid = 1'b0;
    model_reset();
    for (int i = 0; i < L + 3; i++) begin
      advance(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.idle, bus.fa_a, bus.fa_b, bus.fa_op, bus.cnt0, bus.cnt1}
          !== {e_rdy0, e_rdy1, e_rsp0, e_rsp1, e_idle, e_fa, e_cnt}) begin
        fails++;
        $display("FAIL midflight state cyc %0d: got %b_%h_%h exp %b_%h_%h", cyc,
                 {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.idle},
                 {bus.fa_a, bus.fa_b, bus.fa_op}, {bus.cnt0, bus.cnt1},
                 {e_rdy0, e_rdy1, e_rsp0, e_rsp1, e_idle}, e_fa, e_cnt);
      end
    end
  endtask

  task automatic test_stats();
    logic [2*CW-1:0] want;
`ifdef FADD_ARB_STATS_EN
    want = {CW'(5), CW'(3)};
`else
    want = '0;
`endif
    for (int i = 0; i < 8 + L + 2; i++) begin
      advance(i < 5, $urandom, $urandom, 1'b0, (i >= 5) && (i < 8), $urandom, $urandom, 1'b1);
      checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.idle, bus.fa_a, bus.fa_b, bus.fa_op, bus.cnt0, bus.cnt1}
          !== {e_rdy0, e_rdy1, e_rsp0, e_rsp1, e_idle, e_fa, e_cnt}) begin
        fails++;
        $display("FAIL stats state cyc %0d: got %b_%h_%h exp %b_%h_%h", cyc,
                 {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.idle},
                 {bus.fa_a, bus.fa_b, bus.fa_op}, {bus.cnt0, bus.cnt1},
                 {e_rdy0, e_rdy1, e_rsp0, e_rsp1, e_idle}, e_fa, e_cnt);
      end
      if (e_rsp0 || e_rsp1) begin
        checks++;
        if (bus.rsp_data !== e_data) begin
          fails++;
          $display("FAIL stats data cyc %0d: got %h exp %h", cyc, bus.rsp_data, e_data);
        end
      end
      if (i == 8) begin
        checks++;
        if ({bus.cnt0, bus.cnt1} !== want) begin
          fails++;
          $display("FAIL stats counts: got cnt0=%0d cnt1=%0d exp %h", bus.cnt0, bus.cnt1, want);
        end
      end
    end
  endtask

  task automatic test_random();
    logic        p0, p1, o0, o1;
    logic [31:0] a0, b0, a1, b1;
    p0 = 1'b0; p1 = 1'b0; o0 = 1'b0; o1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    for (int i = 0; i < 300 + L + 3; i++) begin
      if (i >= 300) begin
        p0 = 1'b0;
        p1 = 1'b0;
      end else begin
        if (!p0) begin
          if ($urandom_range(0, 1) != 0) begin p0 = 1'b1; a0 = $urandom; b0 = $urandom; o0 = ($urandom_range(0, 1) != 0); end
        end else if ($urandom_range(0, 15) == 0) p0 = 1'b0;
        if (!p1) begin
          if ($urandom_range(0, 1) != 0) begin p1 = 1'b1; a1 = $urandom; b1 = $urandom; o1 = ($urandom_range(0, 1) != 0); end
        end else if ($urandom_range(0, 15) == 0) p1 = 1'b0;
      end
      advance(p0, a0, b0, o0, p1, a1, b1, o1);
      checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.idle, bus.fa_a, bus.fa_b, bus.fa_op, bus.cnt0, bus.cnt1}
          !== {e_rdy0, e_rdy1, e_rsp0, e_rsp1, e_idle, e_fa, e_cnt}) begin
        fails++;
        $display("FAIL random state cyc %0d: got %b_%h_%h exp %b_%h_%h", cyc,
                 {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.idle},
                 {bus.fa_a, bus.fa_b, bus.fa_op}, {bus.cnt0, bus.cnt1},
                 {e_rdy0, e_rdy1, e_rsp0, e_rsp1, e_idle}, e_fa, e_cnt);
      end
      if (e_rsp0 || e_rsp1) begin
        checks++;
        if (bus.rsp_data !== e_data) begin
          fails++;
          $display("FAIL random data cyc %0d: got %h exp %h", cyc, bus.rsp_data, e_data);
        end
      end
      if (e_rdy0) p0 = 1'b0;
      if (e_rdy1) p1 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_stream();
    test_reset_midflight();
    test_stats();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
